// File: rtl/lc3_regfile.sv
// rtl/lc3_regfile.sv - LC-3 8x16 register file with NZP condition codes and pending scoreboard
// Optional same-cycle write-through on both read ports: define REGFILE_BYPASS_EN.
module lc3_regfile #(
    parameter int NREG  = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ld_cc,
    input  logic             rsv_en,
    input  logic [2:0]       rsv_addr,
    input  logic [2:0]       sr1_addr,
    input  logic [2:0]       sr2_addr,
    output logic [WIDTH-1:0] sr1_data,
    output logic [WIDTH-1:0] sr2_data,
    output logic             sr1_ready,
    output logic             sr2_ready,
    output logic [2:0]       nzp,
    output logic [NREG-1:0]  pending
);

    logic [WIDTH-1:0] regs [NREG];
    logic [NREG-1:0]  set_vec;
    logic [NREG-1:0]  clr_vec;
    logic             wr_neg;
    logic             wr_zero;

    always_comb begin
        set_vec = rsv_en ? (NREG'(1) << rsv_addr) : '0;
        clr_vec = wr_en  ? (NREG'(1) << wr_addr)  : '0;
        wr_neg  = wr_data[WIDTH-1];
        wr_zero = (wr_data == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
            nzp     <= 3'b010;
        end else begin
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
            if (wr_en && ld_cc) begin
                nzp <= {wr_neg, wr_zero, !wr_neg && !wr_zero};
            end
            // A reservation on the same edge as the write-back wins: a newer producer is in flight.
            pending <= (pending & ~clr_vec) | set_vec;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic hit1;
    logic hit2;
    logic rsv1;
    logic rsv2;

    always_comb begin
        hit1      = wr_en  && (wr_addr  == sr1_addr);
        hit2      = wr_en  && (wr_addr  == sr2_addr);
        rsv1      = rsv_en && (rsv_addr == sr1_addr);
        rsv2      = rsv_en && (rsv_addr == sr2_addr);
        sr1_data  = hit1 ? wr_data : regs[sr1_addr];
        sr2_data  = hit2 ? wr_data : regs[sr2_addr];
        sr1_ready = (hit1 && !rsv1) || !pending[sr1_addr];
        sr2_ready = (hit2 && !rsv2) || !pending[sr2_addr];
    end
`else
    always_comb begin
        sr1_data  = regs[sr1_addr];
        sr2_data  = regs[sr2_addr];
        sr1_ready = !pending[sr1_addr];
        sr2_ready = !pending[sr2_addr];
    end
`endif

endmodule

// File: tb/tb_lc3_regfile.sv
// tb/tb_lc3_regfile.sv - scoreboard bench for lc3_regfile
module tb_lc3_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        ld_cc;
    logic        rsv_en;
    logic [2:0]  rsv_addr;
    logic [2:0]  sr1_addr;
    logic [2:0]  sr2_addr;
    logic [15:0] sr1_data;
    logic [15:0] sr2_data;
    logic        sr1_ready;
    logic        sr2_ready;
    logic [2:0]  nzp;
    logic [7:0]  pending;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [15:0] exp;
    } item_t;

    item_t sb_q[$];
    item_t it;
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    lc3_regfile dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ld_cc(ld_cc), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .sr1_addr(sr1_addr),
        .sr2_addr(sr2_addr), .sr1_data(sr1_data), .sr2_data(sr2_data),
        .sr1_ready(sr1_ready), .sr2_ready(sr2_ready), .nzp(nzp), .pending(pending)
    );

    task automatic idle();
        wr_en  = 1'b0;
        ld_cc  = 1'b0;
        rsv_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h5A5A; ld_cc = 1'b1;
        rsv_en = 1'b1; rsv_addr = 3'd2;
        @(negedge clk);
        idle();
        sr1_addr = 3'd0; sr2_addr = 3'd2;
        #2 rst_n = 1'b0;
        sb_q.push_back('{"rst_sr1_data", 16'h0000});
        sb_q.push_back('{"rst_sr2_data", 16'h0000});
        sb_q.push_back('{"rst_pending", 16'h0000});
        sb_q.push_back('{"rst_nzp", 16'h0002});
        #1;
        checks++; it = sb_q.pop_front();
        if (sr1_data !== it.exp) begin failures++; $display("FAIL %s got=%h exp=%h", it.name, sr1_data, it.exp); end
        checks++; it = sb_q.pop_front();
        if (sr2_data !== it.exp) begin failures++; $display("FAIL %s got=%h exp=%h", it.name, sr2_data, it.exp); end
        checks++; it = sb_q.pop_front();
        if (16'(pending) !== it.exp) begin failures++; $display("FAIL %s got=%h exp=%h", it.name, pending, it.exp); end
        checks++; it = sb_q.pop_front();
        if (16'(nzp) !== it.exp) begin failures++; $display("FAIL %s got=%b exp=%b", it.name, nzp, it.exp[2:0]); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_nzp();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h8001; ld_cc = 1'b1; sr1_addr = 3'd3;
        sb_q.push_back('{"r3_data", 16'h8001});
        sb_q.push_back('{"nzp_neg", 16'h0004});
        @(negedge clk);
        checks++; it = sb_q.pop_front();
        if (sr1_data !== it.exp) begin failures++; $display("FAIL %s got=%h exp=%h", it.name, sr1_data, it.exp); end
        checks++; it = sb_q.pop_front();
        if (16'(nzp) !== it.exp) begin failures++; $display("FAIL %s got=%b exp=%b", it.name, nzp, it.exp[2:0]); end
        wr_addr = 3'd5; wr_data = 16'h0000;
        sb_q.push_back('{"nzp_zero", 16'h0002});
        @(negedge clk);
        checks++; it = sb_q.pop_front();
        if (16'(nzp) !== it.exp) begin failures++; $display("FAIL %s got=%b exp=%b", it.name, nzp, it.exp[2:0]); end
        wr_addr = 3'd0; wr_data = 16'h0042;
        sb_q.push_back('{"nzp_pos", 16'h0001});
        @(negedge clk);
        checks++; it = sb_q.pop_front();
        if (16'(nzp) !== it.exp) begin failures++; $display("FAIL %s got=%b exp=%b", it.name, nzp, it.exp[2:0]); end
        idle();
    endtask

    task automatic test_ld_cc();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0007; ld_cc = 1'b0; sr1_addr = 3'd2;
        sb_q.push_back('{"r2_data", 16'h0007});
        sb_q.push_back('{"nzp_hold_noldcc", 16'h0001});
        @(negedge clk);
        checks++; it = sb_q.pop_front();
        if (sr1_data !== it.exp) begin failures++; $display("FAIL %s got=%h exp=%h", it.name, sr1_data, it.exp); end
        checks++; it = sb_q.pop_front();
        if (16'(nzp) !== it.exp) begin failures++; $display("FAIL %s got=%b exp=%b", it.name, nzp, it.exp[2:0]); end
        wr_en = 1'b0; ld_cc = 1'b1; wr_addr = 3'd2; wr_data = 16'h8000;
        sb_q.push_back('{"nzp_hold_nowr", 16'h0001});
        sb_q.push_back('{"r2_hold_nowr", 16'h0007});
        @(negedge clk);
        checks++; it = sb_q.pop_front();
        if (16'(nzp) !== it.exp) begin failures++; $display("FAIL %s got=%b exp=%b", it.name, nzp, it.exp[2:0]); end
        checks++; it = sb_q.pop_front();
        if (sr1_data !== it.exp) begin failures++; $display("FAIL %s got=%h exp=%h", it.name, sr1_data, it.exp); end
        idle();
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        rsv_en = 1'b1; rsv_addr = 3'd4; sr2_addr = 3'd4;
        sb_q.push_back('{"rsv4_pending", 16'h0010});
        sb_q.push_back('{"rsv4_ready", 16'h0000});
        @(negedge clk);
        checks++; it = sb_q.pop_front();
        if (16'(pending) !== it.exp) begin failures++; $display("FAIL %s got=%h exp=%h", it.name, pending, it.exp); end
        checks++; it = sb_q.pop_front();
        if (16'(sr2_ready) !== it.exp) begin failures++; $display("FAIL %s got=%b exp=%b", it.name, sr2_ready, it.exp[0]); end
        rsv_en = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0044;
        sb_q.push_back('{"wr4_pending", 16'h0000});
        sb_q.push_back('{"wr4_ready", 16'h0001});
        @(negedge clk);
        checks++; it = sb_q.pop_front();
        if (16'(pending) !== it.exp) begin failures++; $display("FAIL %s got=%h exp=%h", it.name, pending, it.exp); end
        checks++; it = sb_q.pop_front();
        if (16'(sr2_ready) !== it.exp) begin failures++; $display("FAIL %s got=%b exp=%b", it.name, sr2_ready, it.exp[0]); end
        idle();
    endtask

    task automatic test_set_wins();
        @(negedge clk);
        rsv_en = 1'b1; rsv_addr = 3'd6;
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h1234; sr1_addr = 3'd6;
        sb_q.push_back('{"r6_data", 16'h1234});
        sb_q.push_back('{"r6_pending", 16'h0040});
        @(negedge clk);
        idle();
        #1;
        checks++; it = sb_q.pop_front();
        if (sr1_data !== it.exp) begin failures++; $display("FAIL %s got=%h exp=%h", it.name, sr1_data, it.exp); end
        checks++; it = sb_q.pop_front();
        if (16'(pending) !== it.exp) begin failures++; $display("FAIL %s got=%h exp=%h", it.name, pending, it.exp); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        sr1_addr = 3'd1;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hBEEF;
        sb_q.push_back('{"byp_same_cycle", BYP ? 16'hBEEF : 16'h0000});
        #1;
        checks++; it = sb_q.pop_front();
        if (sr1_data !== it.exp) begin failures++; $display("FAIL %s got=%h exp=%h", it.name, sr1_data, it.exp); end
        @(negedge clk);
        idle();
        sb_q.push_back('{"byp_next_cycle", 16'hBEEF});
        #1;
        checks++; it = sb_q.pop_front();
        if (sr1_data !== it.exp) begin failures++; $display("FAIL %s got=%h exp=%h", it.name, sr1_data, it.exp); end
        // R7 reserved, then written while read: ready follows the bypass setting
        @(negedge clk);
        rsv_en = 1'b1; rsv_addr = 3'd7;
        @(negedge clk);
        rsv_en = 1'b0;
        sr2_addr = 3'd7; wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h7777;
        sb_q.push_back('{"byp_ready_same", BYP ? 16'h0001 : 16'h0000});
        #1;
        checks++; it = sb_q.pop_front();
        if (16'(sr2_ready) !== it.exp) begin failures++; $display("FAIL %s got=%b exp=%b", it.name, sr2_ready, it.exp[0]); end
        @(negedge clk);
        idle();
        sb_q.push_back('{"byp_ready_next", 16'h0001});
        #1;
        checks++; it = sb_q.pop_front();
        if (16'(sr2_ready) !== it.exp) begin failures++; $display("FAIL %s got=%b exp=%b", it.name, sr2_ready, it.exp[0]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] m [8];
        logic [7:0]  pend;
        logic [15:0] d1, d2;
        logic        r1, r2;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) m[k] = 16'h0000;
        pend = 8'h00;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            wr_en    = ($urandom_range(0, 2) != 0);
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 16'($urandom);
            ld_cc    = 1'b0;
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = 3'($urandom_range(0, 7));
            sr1_addr = 3'($urandom_range(0, 7));
            sr2_addr = 3'($urandom_range(0, 7));
            d1 = m[sr1_addr]; r1 = !pend[sr1_addr];
            d2 = m[sr2_addr]; r2 = !pend[sr2_addr];
            if (BYP && wr_en && wr_addr == sr1_addr) begin
                d1 = wr_data;
                if (!(rsv_en && rsv_addr == sr1_addr)) r1 = 1'b1;
            end
            if (BYP && wr_en && wr_addr == sr2_addr) begin
                d2 = wr_data;
                if (!(rsv_en && rsv_addr == sr2_addr)) r2 = 1'b1;
            end
            sb_q.push_back('{"b2b_sr1_data", d1});
            sb_q.push_back('{"b2b_sr2_data", d2});
            sb_q.push_back('{"b2b_ready", {14'b0, r1, r2}});
            sb_q.push_back('{"b2b_pending", {8'b0, pend}});
            #1;
            checks++; it = sb_q.pop_front();
            if (sr1_data !== it.exp) begin failures++; $display("FAIL %s n=%0d got=%h exp=%h", it.name, n, sr1_data, it.exp); end
            checks++; it = sb_q.pop_front();
            if (sr2_data !== it.exp) begin failures++; $display("FAIL %s n=%0d got=%h exp=%h", it.name, n, sr2_data, it.exp); end
            checks++; it = sb_q.pop_front();
            if ({14'b0, sr1_ready, sr2_ready} !== it.exp) begin
                failures++; $display("FAIL %s n=%0d got=%b%b exp=%b", it.name, n, sr1_ready, sr2_ready, it.exp[1:0]);
            end
            checks++; it = sb_q.pop_front();
            if (16'(pending) !== it.exp) begin failures++; $display("FAIL %s n=%0d got=%h exp=%h", it.name, n, pending, it.exp); end
            if (wr_en) begin
                m[wr_addr]    = wr_data;
                pend[wr_addr] = 1'b0;
            end
            if (rsv_en) pend[rsv_addr] = 1'b1;
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        wr_addr = 3'd0; wr_data = 16'h0000; rsv_addr = 3'd0;
        sr1_addr = 3'd0; sr2_addr = 3'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_write_nzp();
        test_ld_cc();
        test_scoreboard();
        test_set_wins();
        test_bypass();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
